// File: rtl/alu_cmd_sequencer.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// alu_cmd_sequencer
// Initiator side of the ALU arithmetic interface. Collects a byte-serial
// command frame (HDR, A, B, FUN) from the RX path, issues one ALU operation,
// waits for the result and writes it low byte first to the TX FIFO. If the
// ALU never answers, a single error byte is written instead.
//
// Ports
//   CLK, RST           clock, asynchronous active-low reset
//   RX_DATA, RX_VLD    received byte and its one-cycle strobe
//   ALU_A, ALU_B       zero-extended operands, held until the next issue
//   ALU_FUN            function code (low nibble of the FUN byte)
//   ALU_EN             one-cycle operation enable
//   ALU_OUT, ALU_OUT_VLD  ALU result and its valid strobe
//   TX_DATA, TX_WR     byte and one-cycle write strobe to the TX FIFO
//   TX_FULL            FIFO full, no write may be issued
//   BUSY               high whenever the sequencer is not idle
//   ERR                one-cycle pulse on ALU timeout or dropped RX byte
// ----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] HDR_BYTE    = 8'hCC,
    parameter logic [DATA_WIDTH-1:0] ERR_BYTE    = 8'hEE,
    parameter int                    TIMEOUT_CYC = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] RX_DATA,
    input  logic                  RX_VLD,
    output logic [15:0]           ALU_A,
    output logic [15:0]           ALU_B,
    output logic [3:0]            ALU_FUN,
    output logic                  ALU_EN,
    input  logic [15:0]           ALU_OUT,
    input  logic                  ALU_OUT_VLD,
    output logic [DATA_WIDTH-1:0] TX_DATA,
    output logic                  TX_WR,
    input  logic                  TX_FULL,
    output logic                  BUSY,
    output logic                  ERR
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        GET_A    = 4'd1,
        GET_B    = 4'd2,
        GET_FUN  = 4'd3,
        ISSUE    = 4'd4,
        WAIT_RES = 4'd5,
        SEND_LO  = 4'd6,
        SEND_HI  = 4'd7,
        SEND_ERR = 4'd8
    } state_t;

    state_t                  state_r;
    logic [DATA_WIDTH-1:0]   a_r;
    logic [DATA_WIDTH-1:0]   b_r;
    logic [15:0]             result_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [15:0]             alu_a_r;
    logic [15:0]             alu_b_r;
    logic [3:0]              alu_fun_r;
    logic                    alu_en_r;
    logic [DATA_WIDTH-1:0]   tx_data_r;
    logic                    tx_wr_r;
    logic                    busy_r;
    logic                    err_r;
    logic                    drop_s;

    // A byte arriving once the frame is complete cannot be used and is dropped.
    assign drop_s = RX_VLD && (state_r inside {ISSUE, WAIT_RES, SEND_LO, SEND_HI, SEND_ERR});

    // Frame assembly, ALU handshake and TX write sequencing.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r   <= IDLE;
            a_r       <= {DATA_WIDTH{1'b0}};
            b_r       <= {DATA_WIDTH{1'b0}};
            result_r  <= 16'h0000;
            cnt_r     <= CNT_ZERO;
            alu_a_r   <= 16'h0000;
            alu_b_r   <= 16'h0000;
            alu_fun_r <= 4'h0;
            alu_en_r  <= 1'b0;
            tx_data_r <= {DATA_WIDTH{1'b0}};
            tx_wr_r   <= 1'b0;
            busy_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            // Strobes default low so each is asserted for exactly one cycle.
            alu_en_r <= 1'b0;
            tx_wr_r  <= 1'b0;
            err_r    <= 1'b0;

            case (state_r)
                IDLE: begin
                    if (RX_VLD && (RX_DATA == HDR_BYTE)) begin
                        state_r <= GET_A;
                        busy_r  <= 1'b1;
                    end
                end
                GET_A: begin
                    if (RX_VLD) begin
                        a_r     <= RX_DATA;
                        state_r <= GET_B;
                    end
                end
                GET_B: begin
                    if (RX_VLD) begin
                        b_r     <= RX_DATA;
                        state_r <= GET_FUN;
                    end
                end
                GET_FUN: begin
                    // Operands are presented together with ALU_EN in the ISSUE cycle.
                    if (RX_VLD) begin
                        alu_a_r   <= 16'(a_r);
                        alu_b_r   <= 16'(b_r);
                        alu_fun_r <= RX_DATA[3:0];
                        alu_en_r  <= 1'b1;
                        state_r   <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_r   <= CNT_ZERO;
                    state_r <= WAIT_RES;
                end
                WAIT_RES: begin
                    // A result on the last allowed cycle still counts.
                    if (ALU_OUT_VLD) begin
                        result_r <= ALU_OUT;
                        state_r  <= SEND_LO;
                    end else if (cnt_r == CNT_LAST) begin
                        err_r   <= 1'b1;
                        state_r <= SEND_ERR;
                    end else begin
                        cnt_r <= (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
                    end
                end
                SEND_LO: begin
                    if (!TX_FULL) begin
                        tx_data_r <= result_r[DATA_WIDTH-1:0];
                        tx_wr_r   <= 1'b1;
                        state_r   <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (!TX_FULL) begin
                        tx_data_r <= result_r[2*DATA_WIDTH-1:DATA_WIDTH];
                        tx_wr_r   <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                SEND_ERR: begin
                    if (!TX_FULL) begin
                        tx_data_r <= ERR_BYTE;
                        tx_wr_r   <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase

            if (drop_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign ALU_A   = alu_a_r;
    assign ALU_B   = alu_b_r;
    assign ALU_FUN = alu_fun_r;
    assign ALU_EN  = alu_en_r;
    assign TX_DATA = tx_data_r;
    assign TX_WR   = tx_wr_r;
    assign BUSY    = busy_r;
    assign ERR     = err_r;

endmodule
